// File: rtl/bus_datapath_pkg.sv
// Shared types and control-word layout for the bus datapath.
package bus_datapath_pkg;

  localparam int CTRL_W = 16;

  // Control-word bit positions, as emitted by control_module
  localparam int B_MO  = 0;
  localparam int B_MAI = 1;
  localparam int B_MI  = 2;
  localparam int B_AI  = 3;
  localparam int B_AO  = 4;
  localparam int B_BI  = 5;
  localparam int B_ALO = 6;
  localparam int B_ALS = 7;
  localparam int B_PCI = 8;
  localparam int B_PCO = 9;
  localparam int B_PCS = 10;
  localparam int B_II  = 11;
  localparam int B_OUI = 12;
  localparam int B_CZ  = 13;

  localparam logic TRUE = 1'b1;
  localparam logic ZERO = 1'b0;

  typedef struct packed {
    logic mo, mai, mi, ai, ao, bi, alo, als, pci, pco, pcs, ii, oui, cz;
  } ctrl_t;

  // Unpack the raw control word into named strobes
  function automatic ctrl_t decode(input logic [CTRL_W-1:0] c);
    ctrl_t d;
    d.mo  = c[B_MO];  d.mai = c[B_MAI]; d.mi  = c[B_MI];  d.ai  = c[B_AI];
    d.ao  = c[B_AO];  d.bi  = c[B_BI];  d.alo = c[B_ALO]; d.als = c[B_ALS];
    d.pci = c[B_PCI]; d.pco = c[B_PCO]; d.pcs = c[B_PCS]; d.ii  = c[B_II];
    d.oui = c[B_OUI]; d.cz  = c[B_CZ];
    return d;
  endfunction

  // True when two or more bus drivers are enabled at once
  function automatic logic multi_drv(input logic [3:0] s);
    return (s & (s - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/bus_datapath_alu.sv
// Combinational add/subtract unit with carry out (SUB carry = no borrow).
module alu_unit #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] result,
  output logic         carry
);
  // Subtract as A + ~B + 1 so carry reads as "no borrow"
  assign {carry, result} = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{W{1'b0}}, sub};
endmodule

// File: rtl/bus_datapath.sv
// Executing datapath: registers, shared bus, ALU, RAM and program-load port.
module bus_datapath
  import bus_datapath_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int ADDR_WIDTH      = 8,
  parameter int CONTROL_SIGNALS = CTRL_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CONTROL_SIGNALS-1:0] ctrl,
  output logic [DATA_WIDTH-1:0]      ireg,
  output logic                       zf,
  output logic                       cf,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       out_valid,
  output logic                       bus_err,
  input  logic                       ld_en,
  input  logic [ADDR_WIDTH-1:0]      ld_addr,
  input  logic [DATA_WIDTH-1:0]      ld_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] pc, mar;
  logic [DATA_WIDTH-1:0] a, b, ir, outr, bus;
  logic [DATA_WIDTH-1:0] alu_r, flg_r;
  logic                  alu_c, flg_c;
  logic                  als_q, flag_pend;
  ctrl_t                 cw;
  logic                  unused_ctrl;

  // Control strobes are dead while loading a program or held in reset
  always_comb begin
    cw = '0;
    if (!ld_en && rst) cw = decode(CTRL_W'(ctrl));
  end

  // cz has no datapath effect; spare control bits are ignored
  assign unused_ctrl = ^{ctrl, cw.cz};

  alu_unit #(.W(DATA_WIDTH)) u_alu (
    .a(a), .b(b), .sub(cw.als), .result(alu_r), .carry(alu_c)
  );

  // Second copy evaluates the op captured with B, for the deferred flag latch
  alu_unit #(.W(DATA_WIDTH)) u_flag (
    .a(a), .b(b), .sub(als_q), .result(flg_r), .carry(flg_c)
  );

  // Shared bus: wired-OR of enabled sources, zero when idle
  always_comb begin
    bus = '0;
    if (cw.mo)  bus = bus | mem[mar];
    if (cw.pco) bus = bus | DATA_WIDTH'(pc);
    if (cw.ao)  bus = bus | a;
    if (cw.alo) bus = bus | alu_r;
  end

  // RAM: load port has priority and works regardless of reset
  always_ff @(posedge clk) begin
    if (ld_en)      mem[ld_addr] <= ld_data;
    else if (cw.mi) mem[mar] <= bus;
  end

  // Architectural registers, flags and status
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc <= '0; mar <= '0; a <= '0; b <= '0; ir <= '0; outr <= '0;
      zf <= 1'b0; cf <= 1'b0; als_q <= 1'b0; flag_pend <= 1'b0;
      out_valid <= 1'b0; bus_err <= 1'b0;
    end else begin
      if (cw.mai) mar <= bus[ADDR_WIDTH-1:0];
      if (cw.ai)  a <= bus;
      if (cw.ii)  ir <= bus;
      if (cw.oui) outr <= bus;
      if (cw.pci)      pc <= bus[ADDR_WIDTH-1:0];
      else if (cw.pcs) pc <= pc + 1'b1;
      if (cw.bi) begin
        b     <= bus;
        als_q <= cw.als;
      end
      // Flags latch one edge after B loads, from the A/B of that cycle
      if (flag_pend) begin
        zf <= (flg_r == '0);
        cf <= flg_c;
      end
      flag_pend <= cw.bi;
      out_valid <= cw.oui;
      if (multi_drv({cw.mo, cw.pco, cw.ao, cw.alo})) bus_err <= TRUE;
    end
  end

  assign ireg     = ir;
  assign out_data = outr;

endmodule

// File: tb/tb_bus_datapath.sv
// Scoreboard bench: OUI steps push expected out_data, monitor checks on out_valid.
module tb_bus_datapath;
  import bus_datapath_pkg::*;

  localparam logic [15:0] MO  = 16'd1 << B_MO;
  localparam logic [15:0] MAI = 16'd1 << B_MAI;
  localparam logic [15:0] MI  = 16'd1 << B_MI;
  localparam logic [15:0] AI  = 16'd1 << B_AI;
  localparam logic [15:0] AO  = 16'd1 << B_AO;
  localparam logic [15:0] BI  = 16'd1 << B_BI;
  localparam logic [15:0] ALO = 16'd1 << B_ALO;
  localparam logic [15:0] ALS = 16'd1 << B_ALS;
  localparam logic [15:0] PCI = 16'd1 << B_PCI;
  localparam logic [15:0] PCO = 16'd1 << B_PCO;
  localparam logic [15:0] PCS = 16'd1 << B_PCS;
  localparam logic [15:0] II  = 16'd1 << B_II;
  localparam logic [15:0] OUI = 16'd1 << B_OUI;
  localparam logic [15:0] FETCH = PCO | MAI | PCS;

  logic        clk = 1'b0, rst = 1'b0, ld_en = 1'b0;
  logic [15:0] ctrl = '0;
  logic [7:0]  ld_addr = '0, ld_data = '0;
  logic [7:0]  ireg, out_data;
  logic        zf, cf, out_valid, bus_err;

  int checks = 0, errors = 0;
  logic [7:0] exp_q[$];

  bus_datapath dut (
    .clk(clk), .rst(rst), .ctrl(ctrl), .ireg(ireg), .zf(zf), .cf(cf),
    .out_data(out_data), .out_valid(out_valid), .bus_err(bus_err),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One control cycle; ctrl returns to idle after the edge
  task automatic step(input logic [15:0] c);
    ctrl = c;
    @(posedge clk); #1;
    ctrl = '0;
  endtask

  // Output step: expect this value to appear on out_data with out_valid
  task automatic emit(input logic [15:0] src, input logic [7:0] exp);
    exp_q.push_back(exp);
    step(src | OUI);
  endtask

  task automatic load(input logic [7:0] ad, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = ad; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  // Monitor: every out_valid must match the oldest queued expectation
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: got %h with no pending expectation", out_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          errors++;
          $display("FAIL out_data: got %h expected %h", out_data, e);
        end
      end
    end
  end

  initial begin
    // Program preload while held in reset
    rst = 1'b0;
    @(posedge clk); #1;
    load(8'h00, 8'h1E); load(8'h01, 8'hF0); load(8'h02, 8'h20);
    load(8'h03, 8'h05); load(8'h04, 8'h05); load(8'h05, 8'h06);
    load(8'h06, 8'hFF); load(8'hFF, 8'h40); load(8'h40, 8'h2A);

    // Random ctrl under reset must have no effect
    repeat (2) begin
      ctrl = 16'($urandom);
      @(posedge clk); #1;
    end
    ctrl = '0;
    @(negedge clk);
    chk("rst_ireg", ireg, 8'h00);
    chk("rst_zf", {7'd0, zf}, 8'h00);
    chk("rst_cf", {7'd0, cf}, 8'h00);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_out_valid", {7'd0, out_valid}, 8'h00);
    chk("rst_bus_err", {7'd0, bus_err}, 8'h00);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // Fetch: MAR=0, PC=1, IR=RAM[0]
    step(FETCH);
    step(MO | II);
    @(negedge clk);
    chk("fetch_ireg", ireg, 8'h1E);
    emit(MO, 8'h1E);
    emit(PCO, 8'h01);

    // ADD: A=F0, B=20 -> A=10, cf=1, zf=0
    step(FETCH); step(MO | AI);
    step(FETCH); step(MO | BI);
    step(ALO | AI);
    @(negedge clk);
    chk("add_zf", {7'd0, zf}, 8'h00);
    chk("add_cf", {7'd0, cf}, 8'h01);
    emit(AO, 8'h10);

    // CMP equal: flags land one edge after BI, A untouched
    step(FETCH); step(MO | AI);
    step(FETCH); step(MO | BI | ALS);
    @(negedge clk);
    chk("cmp_eq_zf_early", {7'd0, zf}, 8'h00);
    step(16'h0000);
    @(negedge clk);
    chk("cmp_eq_zf", {7'd0, zf}, 8'h01);
    chk("cmp_eq_cf", {7'd0, cf}, 8'h01);
    emit(AO, 8'h05);

    // CMP with borrow: 5 - 6
    step(FETCH); step(MO | BI | ALS);
    step(16'h0000);
    @(negedge clk);
    chk("cmp_lt_zf", {7'd0, zf}, 8'h00);
    chk("cmp_lt_cf", {7'd0, cf}, 8'h00);
    emit(AO, 8'h05);

    // PC wrap via PCS; PCI beats PCS
    step(FETCH);              // MAR=6 (RAM=FF), PC=7
    step(MO | PCI);           // PC=FF
    step(PCS);                // PC=00
    emit(PCO, 8'h00);
    step(MO | PCI);           // PC=FF
    step(FETCH);              // MAR=FF, PC wraps to 00
    emit(PCO, 8'h00);
    step(MO | PCI | PCS);     // bus=40
    emit(PCO, 8'h40);

    // Memory write through the bus
    step(AO | MI);            // RAM[FF]=05
    emit(MO, 8'h05);
    @(negedge clk);
    chk("no_conflict_bus_err", {7'd0, bus_err}, 8'h00);

    // Bus conflict is sticky
    step(AO | MO);
    @(negedge clk);
    chk("conflict_bus_err", {7'd0, bus_err}, 8'h01);
    step(16'h0000); step(16'h0000);
    @(negedge clk);
    chk("sticky_bus_err", {7'd0, bus_err}, 8'h01);

    // Output of A=2A with single-cycle valid
    step(FETCH);              // MAR=40, PC=41
    step(MO | AI);            // A=2A
    emit(AO, 8'h2A);
    step(16'h0000);
    @(negedge clk);
    chk("out_valid_single", {7'd0, out_valid}, 8'h00);
    chk("out_data_hold", out_data, 8'h2A);

    // Load port suppresses ctrl even when reset is released
    ctrl = FETCH | AO | OUI;
    load(8'h41, 8'h77);
    ctrl = '0;
    emit(PCO, 8'h41);
    step(FETCH);              // MAR=41
    emit(MO, 8'h77);

    step(16'h0000); step(16'h0000);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
